miso_pop_scheduler: RTL
=======================

MISO_POP_SCHEDULER -- requirements
Module: miso_pop_scheduler

Interface
REQ-001 SHALL have parameter NUM_FIFO, default 8, the number of miso_fifo instances (PE rows) sequenced.
REQ-002 SHALL have parameter REUSE_WIDTH, default 4, the width of the reuse-pass counter.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_start, input, 1, a one-cycle request to begin a schedule; honored only in IDLE.
REQ-006 SHALL have port i_abort, input, 1, which terminates any schedule.
REQ-007 SHALL have port i_p_mode, input, 2, the precision mode (00 8x8, 01 4x4, 10 2x2), latched on accepted start.
REQ-008 SHALL have port i_reuse_count, input, REUSE_WIDTH, the number of extra replay passes, latched on accepted start.
REQ-009 SHALL have port i_fifo_empty, input, NUM_FIFO, the per-FIFO empty flags.
REQ-010 SHALL have port o_pop_en, output, NUM_FIFO, the per-FIFO pop enables.
REQ-011 SHALL have port o_p_mode, output, 2, the latched precision mode driven to all FIFOs.
REQ-012 SHALL have port o_r_pointer_reset, output, 1, a read-pointer rewind pulse to all FIFOs.
REQ-013 SHALL have port o_clear, output, 1, a FIFO clear pulse.
REQ-014 SHALL have ports o_busy, o_done (each output, 1) and o_pass_cnt (output, REUSE_WIDTH), giving status, completion pulse and current pass index.

Function
REQ-015 SHALL implement the states IDLE, STREAM, REWIND and DONE.
REQ-016 IDLE SHALL move to STREAM on i_start, latching i_p_mode and i_reuse_count and zeroing skew_cnt, done_mask and pass_cnt.
REQ-017 STREAM SHALL increment skew_cnt by 1 each cycle, saturating at NUM_FIFO-1; FIFO k is "started" when k <= skew_cnt, giving a one-cycle diagonal skew between rows.
REQ-018 o_pop_en[k] SHALL be combinational and high only when state=STREAM, FIFO k is started, done_mask[k]=0 and i_fifo_empty[k]=0.
REQ-019 In STREAM, done_mask[k] SHALL set at the clock edge on which FIFO k is started and i_fifo_empty[k]=1; a FIFO already empty at its start cycle completes immediately.
REQ-020 When all done_mask bits are 1, STREAM SHALL go to REWIND if pass_cnt < latched reuse count, otherwise to DONE.
REQ-021 REWIND SHALL last 1 cycle with o_r_pointer_reset=1, SHALL increment pass_cnt, SHALL clear done_mask and skew_cnt, and SHALL then return to STREAM.
REQ-022 DONE SHALL last 1 cycle with o_done=1 and o_clear=1, and SHALL then go to IDLE.
REQ-023 i_abort in any non-IDLE state SHALL force IDLE on the next edge with o_clear=1 for that one cycle and no o_done; i_abort SHALL take priority over every other transition.
REQ-024 i_start SHALL be ignored outside IDLE; simultaneous i_start and i_abort in IDLE SHALL be ignored.
REQ-025 o_busy SHALL be 1 in every state except IDLE.
REQ-026 o_p_mode and o_pass_cnt SHALL hold their values until the next accepted start.
REQ-027 o_r_pointer_reset, o_clear and o_done SHALL be registered single-cycle pulses.
REQ-028 Precision mode SHALL NOT alter scheduling; packing is the FIFO's responsibility, and emptiness alone terminates a row.
REQ-029 i_reuse_count=0 SHALL give exactly one pass with no REWIND; the maximum value 2^REUSE_WIDTH-1 SHALL give that many replays, with pass_cnt never wrapping.

Reset
REQ-030 While i_rst=1, state SHALL be IDLE, skew_cnt, done_mask and pass_cnt SHALL be 0, and all outputs SHALL be 0 (o_p_mode=00), independent of the clock.
REQ-031 Reset asserted mid-schedule SHALL abandon the schedule with no o_done or o_clear pulse.
REQ-032 After reset deassertion, the first i_start SHALL be accepted on the next edge.

Verification
REQ-033 Diagonal skew: NUM_FIFO=8, each FIFO holds 3 entries, reuse=0, start -> o_pop_en[k] first high k cycles after entering STREAM, 3 pops per row, o_done 1 cycle after done_mask=FF, o_clear coincident with o_done.
REQ-034 Replay: reuse=2, each FIFO holds 2 entries -> exactly 2 o_r_pointer_reset pulses, o_pass_cnt stepping 0,1,2, 6 pops per row, then one o_done.
REQ-035 Empty row: FIFO 3 empty at start -> o_pop_en[3] never asserted, done_mask[3] set at skew_cnt=3, schedule completes normally.
REQ-036 Abort: i_abort during the second pass -> state IDLE next cycle, o_clear=1 for one cycle, o_done=0, o_pop_en=0.
REQ-037 Start outside IDLE: i_start pulsed in STREAM and REWIND -> no effect on the latched mode, counts or pass_cnt.
REQ-038 Mid-run reset: i_rst asserted asynchronously during STREAM -> all outputs 0 immediately with no pulses; a new i_start after release runs a full schedule.

Source files
------------

// File: rtl/miso_pop_scheduler.sv
// miso_pop_scheduler: sequences pops across NUM_FIFO miso_fifo rows with a
// one-cycle diagonal skew between rows, optional replay passes via read-pointer
// rewind, and a clear/done handshake at the end of a schedule.
module miso_pop_scheduler #(
  parameter int unsigned NUM_FIFO    = 8,
  parameter int unsigned REUSE_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [1:0]             i_p_mode,
  input  logic [REUSE_WIDTH-1:0] i_reuse_count,
  input  logic [NUM_FIFO-1:0]    i_fifo_empty,
  output logic [NUM_FIFO-1:0]    o_pop_en,
  output logic [1:0]             o_p_mode,
  output logic                   o_r_pointer_reset,
  output logic                   o_clear,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [REUSE_WIDTH-1:0] o_pass_cnt
);

  localparam int unsigned SKEW_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
  localparam logic [SKEW_W-1:0] SKEW_MAX = SKEW_W'(NUM_FIFO - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REWIND = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SKEW_W-1:0]      skew_q, skew_d;
  logic [NUM_FIFO-1:0]    mask_q, mask_d;
  logic [REUSE_WIDTH-1:0] pass_q, pass_d;
  logic [REUSE_WIDTH-1:0] reuse_q, reuse_d;
  logic [1:0]             mode_q, mode_d;
  logic                   rptr_q, rptr_d;
  logic                   clear_q, clear_d;
  logic                   done_q, done_d;
  logic [NUM_FIFO-1:0]    started;
  logic                   all_done;

  // Row k has been released once the skew counter has reached k.
  always_comb begin
    started = '0;
    for (int k = 0; k < NUM_FIFO; k++) begin
      started[k] = (skew_q >= SKEW_W'(k));
    end
  end

  assign all_done = &mask_q;

  assign o_pop_en          = (state_q == STREAM) ? (started & ~mask_q & ~i_fifo_empty) : '0;
  assign o_busy            = (state_q != IDLE);
  assign o_p_mode          = mode_q;
  assign o_pass_cnt        = pass_q;
  assign o_r_pointer_reset = rptr_q;
  assign o_clear           = clear_q;
  assign o_done            = done_q;

  // Next-state, counter updates and registered pulse generation.
  always_comb begin
    state_d = state_q;
    skew_d  = skew_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    reuse_d = reuse_q;
    mode_d  = mode_q;
    rptr_d  = 1'b0;
    clear_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          state_d = STREAM;
          mode_d  = i_p_mode;
          reuse_d = i_reuse_count;
          skew_d  = '0;
          mask_d  = '0;
          pass_d  = '0;
        end
      end
      STREAM: begin
        if (all_done) begin
          if (pass_q < reuse_q) begin
            state_d = REWIND;
            rptr_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            clear_d = 1'b1;
          end
        end else begin
          skew_d = (skew_q == SKEW_MAX) ? skew_q : skew_q + SKEW_W'(1);
          mask_d = mask_q | (started & i_fifo_empty);
        end
      end
      REWIND: begin
        state_d = STREAM;
        pass_d  = pass_q + REUSE_WIDTH'(1);
        mask_d  = '0;
        skew_d  = '0;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything once a schedule is running.
    if (i_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      skew_d  = skew_q;
      mask_d  = mask_q;
      pass_d  = pass_q;
      rptr_d  = 1'b0;
      done_d  = 1'b0;
      clear_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      skew_q  <= '0;
      mask_q  <= '0;
      pass_q  <= '0;
      reuse_q <= '0;
      mode_q  <= 2'b00;
      rptr_q  <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skew_q  <= skew_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      reuse_q <= reuse_d;
      mode_q  <= mode_d;
      rptr_q  <= rptr_d;
      clear_q <= clear_d;
      done_q  <= done_d;
    end
  end

endmodule
